// File: rtl/nv_nvdla_cdma_wg_pfifo.sv
// nv_nvdla_cdma_wg_pfifo
// Parametrised single-clock valid/ready FIFO for the CDMA weight-group path.
// Entries live in a flop array. A registered output stage presents the head,
// so a write into an empty FIFO is readable one cycle later, and the next head
// appears with no bubble after a pop.
// Optional feature: define NV_CDMA_PFIFO_WR_LIMIT_EN to add the wr_limit port.
// wr_limit is a runtime capacity cap. A value of 0, or any value above DEPTH,
// means DEPTH.
module nv_nvdla_cdma_wg_pfifo #(
  parameter int WIDTH    = 5,
  parameter int DEPTH    = 128,
  parameter int AF_LEVEL = DEPTH - 8,
  localparam int CW      = $clog2(DEPTH + 1),
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             flush,
  input  logic             wr_req,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_req,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    wr_count,
`ifdef NV_CDMA_PFIFO_WR_LIMIT_EN
  input  logic [CW-1:0]    wr_limit,
`endif
  output logic             wr_almost_full
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             wr_ready_q, wr_ready_d;
  logic             rd_req_q, rd_req_d;
  logic             af_q, af_d;
  logic [CW-1:0]    limit;
  logic             push, pop;

`ifdef NV_CDMA_PFIFO_WR_LIMIT_EN
  // Effective cap: zero or out-of-range values fall back to the full depth.
  always_comb begin
    limit = CW'(DEPTH);
    if (wr_limit != '0 && wr_limit <= CW'(DEPTH)) limit = wr_limit;
  end
`else
  assign limit = CW'(DEPTH);
`endif

  assign push = wr_req & wr_ready_q;
  assign pop  = rd_req_q & rd_ready;

  // Next-state: pointers, occupancy, and the head of the post-update contents.
  always_comb begin
    wr_ptr_d  = wr_ptr_q + AW'(push);
    rd_ptr_d  = rd_ptr_q + AW'(pop);
    count_d   = count_q + CW'(push) - CW'(pop);
    rd_data_d = rd_data_q;
    if (count_d != '0) begin
      // The new head is the word being written now if it lands on the head
      // slot. That happens on a push into an empty FIFO, or on a push and pop
      // at count 1.
      if (push && (wr_ptr_q == rd_ptr_d)) rd_data_d = wr_data;
      else                                rd_data_d = mem_q[rd_ptr_d];
    end
    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      rd_data_d = rd_data_q;
    end
    wr_ready_d = (count_d < limit);
    rd_req_d   = (count_d != '0);
    af_d       = (count_d >= CW'(AF_LEVEL));
  end

  // Control state and output register; reset also clears the output data.
  always_ff @(posedge clk) begin
    if (reset_) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      wr_ready_q <= 1'b1;
      rd_req_q   <= 1'b0;
      af_q       <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      wr_ready_q <= wr_ready_d;
      rd_req_q   <= rd_req_d;
      af_q       <= af_d;
    end
  end

  // Storage array write; not reset, contents are qualified by occupancy.
  always_ff @(posedge clk) begin
    if (push && !flush && !reset_) mem_q[wr_ptr_q] <= wr_data;
  end

  assign wr_ready       = wr_ready_q;
  assign rd_req         = rd_req_q;
  assign rd_data        = rd_data_q;
  assign wr_count       = count_q;
  assign wr_almost_full = af_q;

endmodule
